mu0_fbc_control_fsm: RTL
========================

# mu0_fbc_control_fsm

Control state machine for the MU0 datapath extended with the FBC (Fibonacci) instruction. It sequences every instruction through FETCH/EXEC1/EXEC2 and drives the one-hot phase strobes and `Fib_Check` consumed by the Fibonacci ALU decoder. It also consumes that decoder's `FBC_State` to keep an FBC instruction iterating in EXEC2 until the result is captured. An iteration counter provides a hard bound on FBC run time and reports completion and timeout status.

## Interface
- `OPC_W`, 4, opcode width (IR[15:12]).
- `OPC_LDA`/`OPC_ADD`/`OPC_SUB`, 0/2/3, opcodes that need the EXEC2 memory cycle.
- `OPC_STP`, 7, stop opcode.
- `OPC_FBC`, 8, Fibonacci opcode.
- `MAX_ITER`, 4095, maximum EXEC2 cycles per FBC instruction (12-bit).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Run` in 1: leaves IDLE when high.
- `IR_Opcode` in OPC_W: IR opcode field, stable from the end of FETCH to the end of the instruction.
- `FBC_State` in 1: from the Fibonacci decoder; 1 = FBC not yet complete.
- `Fetch`, `Exec1`, `Exec2` out 1 each: registered one-hot phase strobes.
- `Halted` out 1: high in HALT.
- `Fib_Check` out 1: `(Exec1|Exec2) & (IR_Opcode==OPC_FBC)`. Combinational and independent of `FBC_State`, so no loop forms through the decoder.
- `Fib_Iter` out 12: number of EXEC2 cycles spent in the current or last FBC instruction.
- `Fib_Done` out 1: one-cycle pulse on normal FBC completion.
- `Fib_Timeout` out 1: sticky; set on an iteration-limit exit.

## Operation
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. Encoding is free, but the phase outputs are one-hot decodes of the state register.
- Transitions out of IDLE and FETCH:
  - IDLE: `Run` → FETCH, else stay.
  - FETCH → EXEC1 unconditionally.
- Transitions out of EXEC1, evaluated in priority order:
  - opcode = STP → HALT.
  - opcode = FBC and `FBC_State` → EXEC2.
  - opcode = FBC and !`FBC_State` → FETCH (base case resolved in EXEC1).
  - opcode ∈ {LDA, ADD, SUB} → EXEC2.
  - otherwise → FETCH.
- Transitions out of EXEC2:
  - Non-FBC opcode: → FETCH after one cycle.
  - FBC opcode: stay while `FBC_State`=1 and `Fib_Iter` < MAX_ITER. Otherwise → FETCH.
- HALT: absorbing. Only `rst_n` leaves it; `Run` is ignored.
- Fib_Iter:
  - Cleared to 0 on the EXEC1 cycle of an FBC instruction.
  - Incremented on every FBC EXEC2 cycle.
  - Saturates at MAX_ITER, never wraps.
  - Holds its value after the instruction.
- Fib_Done: asserted for the single cycle after an FBC exit to FETCH caused by `FBC_State`=0, from either EXEC1 or EXEC2.
- Fib_Timeout:
  - Set when FBC exits EXEC2 with `FBC_State`=1 and `Fib_Iter`=MAX_ITER; no Fib_Done pulse in that case.
  - Cleared at the EXEC1 of the next FBC instruction.
- Unknown opcodes behave as single-cycle EXEC1 instructions.

## Timing
- Reset values: state = IDLE.
  - `Fetch`=`Exec1`=`Exec2`=`Halted`=`Fib_Done`=`Fib_Timeout`=0.
  - `Fib_Iter`=0.
  - `Fib_Check`=0, which follows from the zero phase strobes.
- All outputs except `Fib_Check` are registered. Each phase lasts exactly one clock per visit, except FBC EXEC2, which repeats.
- Instruction latency:
  - Plain instruction: 2 cycles.
  - LDA/ADD/SUB: 3 cycles.
  - FBC base case: 2 cycles.
  - FBC with k EXEC2 cycles: 2+k cycles, where k ≤ MAX_ITER.
- `FBC_State` is sampled at the clock edge ending each EXEC1/EXEC2 cycle. The decoder must settle it within that cycle.
- Reset asserted mid-instruction, including mid-FBC: asynchronous return to IDLE and all outputs cleared immediately. Restart requires `Run`.
- If `FBC_State`=0 and `Fib_Iter`=MAX_ITER in the same cycle, completion wins: Fib_Done pulses and Fib_Timeout stays 0.
- With `Run` held low after reset, the FSM stays in IDLE indefinitely with no strobes.

## Test plan
- Reset, then `Run`=1 with opcode JMP (4): strobes run Fetch→Exec1→Fetch in 2-cycle periods. Fib_Check stays 0 throughout.
- Opcode ADD (2): Fetch, Exec1, Exec2, Fetch. Exec2 is high for exactly one cycle.
- Opcode FBC with `FBC_State`=0 in EXEC1 (N=0/1 base case): back to FETCH next cycle. Fib_Done pulses once, Fib_Iter=0, Fib_Check high only during Exec1.
- Opcode FBC with `FBC_State`=1 for 5 EXEC2 cycles, then 0: Exec2 stays high for 6 cycles. Fib_Iter=6, Fib_Done pulses in the following FETCH cycle, Fib_Timeout=0.
- Opcode FBC with `FBC_State` stuck at 1 and MAX_ITER=7: exits after 7 EXEC2 cycles with Fib_Timeout=1 and no Fib_Done. The next FBC clears Fib_Timeout at its EXEC1.
- Opcode STP: HALT reached, Halted=1, and it persists through 20 cycles with `Run`=1. Pulsing `rst_n` low mid-FBC EXEC2 clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/mu0_fbc_control_fsm.sv
// MU0 control sequencer with FBC (Fibonacci) iteration support.
// Drives phase strobes, Fib_Check, and bounded FBC iteration status.
module mu0_fbc_control_fsm #(
  parameter int OPC_W = 4,
  parameter logic [OPC_W-1:0] OPC_LDA = 4'd0,
  parameter logic [OPC_W-1:0] OPC_ADD = 4'd2,
  parameter logic [OPC_W-1:0] OPC_SUB = 4'd3,
  parameter logic [OPC_W-1:0] OPC_STP = 4'd7,
  parameter logic [OPC_W-1:0] OPC_FBC = 4'd8,
  parameter int MAX_ITER = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Run,
  input  logic [OPC_W-1:0] IR_Opcode,
  input  logic             FBC_State,
  output logic             Fetch,
  output logic             Exec1,
  output logic             Exec2,
  output logic             Halted,
  output logic             Fib_Check,
  output logic [11:0]      Fib_Iter,
  output logic             Fib_Done,
  output logic             Fib_Timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [11:0] MAX_L = 12'(MAX_ITER);

  state_t      state;
  state_t      state_nxt;
  logic [11:0] iter_nxt;
  logic [11:0] iter_inc;
  logic        done_nxt;
  logic        to_nxt;
  logic        is_fbc;
  logic        is_mem;

  assign is_fbc = (IR_Opcode == OPC_FBC);
  assign is_mem = (IR_Opcode == OPC_LDA) ||
                  (IR_Opcode == OPC_ADD) ||
                  (IR_Opcode == OPC_SUB);

  // Count includes the current EXEC2 cycle; saturating.
  assign iter_inc = (Fib_Iter >= MAX_L) ? MAX_L
                                        : Fib_Iter + 12'd1;

  assign Fetch     = (state == S_FETCH);
  assign Exec1     = (state == S_EXEC1);
  assign Exec2     = (state == S_EXEC2);
  assign Halted    = (state == S_HALT);
  assign Fib_Check = (Exec1 | Exec2) & is_fbc;

  always_comb begin
    state_nxt = state;
    iter_nxt  = Fib_Iter;
    done_nxt  = 1'b0;
    to_nxt    = Fib_Timeout;
    case (state)
      S_IDLE: begin
        if (Run) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (IR_Opcode == OPC_STP) begin
          state_nxt = S_HALT;
        end else if (is_fbc) begin
          iter_nxt = 12'd0;
          to_nxt   = 1'b0;
          if (FBC_State) begin
            state_nxt = S_EXEC2;
          end else begin
            state_nxt = S_FETCH;
            done_nxt  = 1'b1;
          end
        end else if (is_mem) begin
          state_nxt = S_EXEC2;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_EXEC2: begin
        state_nxt = S_FETCH;
        if (is_fbc) begin
          iter_nxt = iter_inc;
          if (FBC_State && iter_inc < MAX_L) begin
            state_nxt = S_EXEC2;
          end else if (!FBC_State) begin
            done_nxt = 1'b1;
          end else begin
            to_nxt = 1'b1;
          end
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      Fib_Iter    <= 12'd0;
      Fib_Done    <= 1'b0;
      Fib_Timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      Fib_Iter    <= iter_nxt;
      Fib_Done    <= done_nxt;
      Fib_Timeout <= to_nxt;
    end
  end

endmodule
